alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//   Parametrised, handshaked successor of the processor's 8-bit combinational ALU.
//   Adds SUB and three shifts; shifts run iteratively over several cycles.
//   Sits between register-file read and writeback in the multi-cycle datapath.
//   Result is registered; ZERO flag feeds branch logic.
// PARAMETERS
//   WIDTH       8   operand/result width in bits; must be >= 2.
//   SHIFT_STEP  1   bits shifted per cycle in SHIFT state; power of 2, <= WIDTH.
// PORTS
//   CLK        in   1      single clock; all state updates on the rising edge.
//   RESET      in   1      synchronous, active-low reset.
//   IN_VALID   in   1      operation request valid.
//   IN_READY   out  1      block accepts a request this cycle.
//   DATA1      in   WIDTH  operand 1; value shifted for shift ops.
//   DATA2      in   WIDTH  operand 2; DATA2[$clog2(WIDTH):0] is the shift amount.
//   SELECT     in   3      000 FWD, 001 ADD, 010 AND, 011 OR, 100 SUB, 101 SLL, 110 SRL, 111 SRA.
//   OUT_VALID  out  1      RESULT/flags valid.
//   OUT_READY  in   1      consumer takes the result this cycle.
//   RESULT     out  WIDTH  registered result.
//   ZERO       out  1      RESULT == 0, registered with RESULT.
//   CARRY      out  1      present only with ALU_FLAGS_EN; see CONFIGURATION.
//   OVERFLOW   out  1      present only with ALU_FLAGS_EN; see CONFIGURATION.
// BEHAVIOUR
//   - Reset (RESET==0 at an edge): state IDLE, OUT_VALID=0, RESULT=0, ZERO=1, CARRY=0,
//     OVERFLOW=0. An in-flight shift is abandoned. IN_READY=0 while RESET is low.
//   - Accept: a transfer occurs when IN_VALID && IN_READY at an edge.
//     IN_READY = (state==IDLE) && (!OUT_VALID || OUT_READY).
//   - Output: OUT_VALID stays high and RESULT/flags stay stable until OUT_VALID && OUT_READY.
//     OUT_VALID then drops, unless a new result loads on the same edge.
//   - FWD, ADD, SUB, AND and OR: the result loads on the accept edge. Latency is 1 cycle.
//     Back-to-back accepts give 1 result per cycle while OUT_READY=1.
//   - ADD and SUB are modulo 2^WIDTH. SUB = DATA1 - DATA2 (two's complement).
//   - Shifts: amount N = DATA2[$clog2(WIDTH):0], saturated to WIDTH.
//     N >= WIDTH gives 0 for SLL/SRL and all sign bits for SRA.
//     N == 0: behaves as a 1-cycle op, RESULT = DATA1.
//     N > 0: the accept edge latches DATA1 and N and moves IDLE -> SHIFT.
//     Each SHIFT cycle shifts by min(SHIFT_STEP, remaining) and decrements remaining.
//     The edge that reaches remaining==0 loads RESULT, sets OUT_VALID and returns to IDLE.
//     Latency = ceil(N/SHIFT_STEP) + 1 cycles from accept to OUT_VALID.
//   - FSM: IDLE --accept shift, N>0--> SHIFT. SHIFT --remaining reaches 0--> IDLE.
//     No other transitions except reset. IN_READY=0 throughout SHIFT.
//   - Operands are sampled only at accept; later DATA1/DATA2/SELECT changes are ignored.
// CONFIGURATION
//   ALU_FLAGS_EN defined: CARRY and OVERFLOW ports exist.
//     ADD: CARRY = carry-out; OVERFLOW = signed overflow.
//     SUB: CARRY = 1 when no borrow (DATA1 >= DATA2 unsigned); OVERFLOW = signed overflow.
//     Shifts with N in 1..WIDTH: CARRY = last bit shifted out; OVERFLOW = 0.
//     Shifts with N == 0 and logic/FWD ops: CARRY = 0, OVERFLOW = 0.
//     Flags are registered and held exactly like RESULT.
//   ALU_FLAGS_EN undefined: ports absent, no flag logic. ZERO always present.
// STRUCTURE
//   - alu_pkg holds the SELECT encodings (ALU_FWD..ALU_SRA) as 3-bit localparams,
//     and the FSM state encodings (ST_IDLE, ST_SHIFT).
//   - One sub-module, alu_shifter: iterative SLL/SRL/SRA unit.
//     Ports: start, op, value, amount, busy, done, result, carry_out.
//     The top owns the handshake, the 1-cycle ops and the output register.
// TESTING
//   - Reset: RESET=0 for 2 cycles mid-shift (SLL, N=5) -> OUT_VALID=0, RESULT=0, ZERO=1,
//     and IN_READY=1 the cycle after RESET rises.
//   - 1-cycle ops, WIDTH=8, OUT_READY=1: ADD 8'h8F+8'h09 -> 8'h98; SUB 8'h05-8'h05 -> 8'h00
//     with ZERO=1; AND 8'h0F&8'h59 -> 8'h09; OR 8'h0F|8'h79 -> 8'h7F.
//     Back-to-back, each result 1 cycle after its accept.
//   - Shifts, SHIFT_STEP=1: SRA 8'h90 by 3 -> 8'hF2, OUT_VALID 4 cycles after accept,
//     IN_READY=0 meanwhile. SRL 8'h90 by 9 -> 8'h00. SLL 8'h81 by 0 -> 8'h81 in 1 cycle.
//   - Backpressure: OUT_READY=0 for 5 cycles after ADD 1+2 -> RESULT held at 3,
//     IN_READY=0, a second IN_VALID is not accepted. It is accepted on the edge
//     where OUT_READY rises.
//   - SHIFT_STEP=4, WIDTH=16: SLL 16'h0001 by 10 -> 16'h0400, OUT_VALID 4 cycles after accept.
//   - ALU_FLAGS_EN: ADD 8'h7F+8'h01 -> 8'h80, CARRY=0, OVERFLOW=1.
//     SUB 8'h00-8'h01 -> 8'hFF, CARRY=0. SRL 8'h03 by 1 -> CARRY=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the pipelined ALU: SELECT opcodes, FSM states and
// a small opcode-classification helper.
package alu_pkg;

    localparam logic [2:0] ALU_FWD = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SRL = 3'b110;
    localparam logic [2:0] ALU_SRA = 3'b111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic logic is_shift_op(input logic [2:0] sel);
        return (sel == ALU_SLL) || (sel == ALU_SRL) || (sel == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Request/response bundle of the pipelined ALU.
// Optional macro ALU_FLAGS_EN adds the carry and overflow signals.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. The
// producer holds valid and its payload stable until the transfer happens.
interface alu_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic [2:0]       select;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
`ifdef ALU_FLAGS_EN
    logic             carry;
    logic             overflow;

    modport master (
        output in_valid, data1, data2, select, out_ready,
        input  in_ready, out_valid, result, zero, carry, overflow
    );
    modport slave (
        input  in_valid, data1, data2, select, out_ready,
        output in_ready, out_valid, result, zero, carry, overflow
    );
`else
    modport master (
        output in_valid, data1, data2, select, out_ready,
        input  in_ready, out_valid, result, zero
    );
    modport slave (
        input  in_valid, data1, data2, select, out_ready,
        output in_ready, out_valid, result, zero
    );
`endif
endinterface

// File: rtl/alu_shifter.sv
// Iterative SLL/SRL/SRA unit: shifts by up to SHIFT_STEP bits per cycle.
// done is asserted combinationally in the cycle whose edge finishes the
// shift; result/carry_out are valid while done is high.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int SHIFT_STEP = 1,
    parameter int AW         = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] value,
    input  logic [AW-1:0]    amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);
    localparam logic [AW-1:0] STEP = AW'(SHIFT_STEP);

    logic [WIDTH-1:0] value_q;
    logic [AW-1:0]    rem_q;
    logic [2:0]       op_q;
    logic             busy_q;
    logic [AW-1:0]    step;
    logic [WIDTH:0]   ext;

    // Bits moved this cycle: a full step, or whatever is left.
    assign step = (rem_q > STEP) ? STEP : rem_q;
    assign busy = busy_q;
    assign done = busy_q && (rem_q <= STEP);

    // One step of the shift; the extra bit of ext catches the last bit shifted out.
    always_comb begin
        ext       = '0;
        result    = value_q;
        carry_out = 1'b0;
        case (op_q)
            ALU_SLL: begin
                ext       = {1'b0, value_q} << step;
                result    = ext[WIDTH-1:0];
                carry_out = ext[WIDTH];
            end
            ALU_SRL: begin
                ext       = {value_q, 1'b0} >> step;
                result    = ext[WIDTH:1];
                carry_out = ext[0];
            end
            default: begin
                ext       = $signed({value_q, 1'b0}) >>> step;
                result    = ext[WIDTH:1];
                carry_out = ext[0];
            end
        endcase
    end

    // Latch the operand on start, then advance one step per cycle until done.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_q  <= 1'b0;
            value_q <= '0;
            rem_q   <= '0;
            op_q    <= ALU_SLL;
        end else if (start) begin
            busy_q  <= 1'b1;
            value_q <= value;
            rem_q   <= amount;
            op_q    <= op;
        end else if (busy_q) begin
            value_q <= result;
            rem_q   <= rem_q - step;
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU with a registered result. Single-cycle ops load the output
// register on the accept edge; shifts with a non-zero amount go through
// alu_shifter and load when it finishes.
// Optional macro ALU_FLAGS_EN adds registered carry and overflow outputs.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int SHIFT_STEP = 1
) (
    input  logic  clk,
    input  logic  reset,
    alu_pipe_if.slave bus,
    output state_t dbg_state
);
    localparam int AW = $clog2(WIDTH) + 1;
    localparam logic [AW-1:0] WIDTH_A = AW'(WIDTH);

    state_t           state;
    state_t           state_next;
    logic             in_ready;
    logic             accept;
    logic             shift_start;
    logic             shift_done;
    logic             shift_carry;
    logic             unused_busy;
    logic [WIDTH-1:0] shift_result;
    logic [AW-1:0]    amt_raw;
    logic [AW-1:0]    amt_sat;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH-1:0] fast_result;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;

    assign amt_raw     = bus.data2[AW-1:0];
    assign amt_sat     = (amt_raw > WIDTH_A) ? WIDTH_A : amt_raw;
    assign in_ready    = reset && (state == ST_IDLE) && (!out_valid_q || bus.out_ready);
    assign accept      = bus.in_valid && in_ready;
    assign shift_start = accept && is_shift_op(bus.select) && (amt_sat != '0);
    assign sum_ext     = {1'b0, bus.data1} + {1'b0, bus.data2};
    assign diff_ext    = {1'b0, bus.data1} - {1'b0, bus.data2};

    // Output register loads from the fast path on a non-iterative accept,
    // or from the shifter on its final step; the two never coincide.
    assign load       = (accept && !shift_start) || shift_done;
    assign load_value = shift_done ? shift_result : fast_result;

    alu_shifter #(
        .WIDTH      (WIDTH),
        .SHIFT_STEP (SHIFT_STEP),
        .AW         (AW)
    ) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .start     (shift_start),
        .op        (bus.select),
        .value     (bus.data1),
        .amount    (amt_sat),
        .busy      (unused_busy),
        .done      (shift_done),
        .result    (shift_result),
        .carry_out (shift_carry)
    );

    // Single-cycle results; zero-amount shifts fall through to forwarding DATA1.
    always_comb begin
        fast_result = bus.data1;
        case (bus.select)
            ALU_ADD: fast_result = sum_ext[WIDTH-1:0];
            ALU_SUB: fast_result = diff_ext[WIDTH-1:0];
            ALU_AND: fast_result = bus.data1 & bus.data2;
            ALU_OR:  fast_result = bus.data1 | bus.data2;
            default: fast_result = bus.data1;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: enter SHIFT on an iterative accept, leave when the shifter finishes.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (shift_start) state_next = ST_SHIFT;
            ST_SHIFT: if (shift_done)  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Output register: hold until consumed, reload whenever a new result is ready.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
        end else if (load) begin
            out_valid_q <= 1'b1;
            result_q    <= load_value;
            zero_q      <= (load_value == '0);
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

`ifdef ALU_FLAGS_EN
    logic fast_carry;
    logic fast_ovf;
    logic carry_q;
    logic ovf_q;

    // Carry/overflow for ADD and SUB; every other single-cycle op clears both.
    always_comb begin
        fast_carry = 1'b0;
        fast_ovf   = 1'b0;
        case (bus.select)
            ALU_ADD: begin
                fast_carry = sum_ext[WIDTH];
                fast_ovf   = (bus.data1[WIDTH-1] == bus.data2[WIDTH-1]) &&
                             (sum_ext[WIDTH-1] != bus.data1[WIDTH-1]);
            end
            ALU_SUB: begin
                fast_carry = ~diff_ext[WIDTH];
                fast_ovf   = (bus.data1[WIDTH-1] != bus.data2[WIDTH-1]) &&
                             (diff_ext[WIDTH-1] != bus.data1[WIDTH-1]);
            end
            default: begin
                fast_carry = 1'b0;
                fast_ovf   = 1'b0;
            end
        endcase
    end

    // Flags load and hold in lockstep with the result register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (load) begin
            carry_q <= shift_done ? shift_carry : fast_carry;
            ovf_q   <= shift_done ? 1'b0 : fast_ovf;
        end
    end

    assign bus.carry    = carry_q;
    assign bus.overflow = ovf_q;
`else
    logic unused_flags;
    assign unused_flags = ^{sum_ext[WIDTH], diff_ext[WIDTH], shift_carry};
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: an 8-bit/step-1 instance checked every
// cycle against a behavioural model, plus a 16-bit/step-4 instance.
// Define ALU_FLAGS_EN to also check carry/overflow.
module tb_alu_pipe;
    import alu_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    int   cycle = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    int checks = 0;
    int errors = 0;

    alu_pipe_if #(.WIDTH(8))  bus8 ();
    alu_pipe_if #(.WIDTH(16)) bus16 ();
    state_t st8;
    state_t st16;

    alu_pipe #(.WIDTH(8), .SHIFT_STEP(1)) dut8 (
        .clk(clk), .reset(reset), .bus(bus8), .dbg_state(st8)
    );
    alu_pipe #(.WIDTH(16), .SHIFT_STEP(4)) dut16 (
        .clk(clk), .reset(reset), .bus(bus16), .dbg_state(st16)
    );

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    logic [1:0] flag_q[$];   // {overflow, carry}
    int         due_q[$];    // cycle count at which the result must first be seen

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Behavioural model: returns {overflow, carry, result[7:0]}.
    function automatic logic [9:0] model8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int n;
        int sa;
        int sb;
        int s;
        logic [7:0] r;
        logic c;
        logic v;
        n  = int'(b[3:0]);
        if (n > 8) n = 8;
        sa = int'($signed(a));
        sb = int'($signed(b));
        r  = a;
        c  = 1'b0;
        v  = 1'b0;
        case (op)
            ALU_ADD: begin
                r = a + b;
                c = (int'(a) + int'(b)) > 255;
                s = sa + sb;
                v = (s > 127) || (s < -128);
            end
            ALU_SUB: begin
                r = a - b;
                c = (a >= b);
                s = sa - sb;
                v = (s > 127) || (s < -128);
            end
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_SLL: begin
                r = a << n;
                if (n > 0) c = a[8-n];
            end
            ALU_SRL: begin
                r = a >> n;
                if (n > 0) c = a[n-1];
            end
            ALU_SRA: begin
                r = 8'($signed(a) >>> n);
                if (n > 0) c = a[n-1];
            end
            default: r = a;
        endcase
        return {v, c, r};
    endfunction

    function automatic int lat8(input logic [2:0] op, input logic [7:0] b);
        int n;
        n = int'(b[3:0]);
        if (n > 8) n = 8;
        if ((op == ALU_SLL || op == ALU_SRL || op == ALU_SRA) && n > 0) return n + 1;
        return 1;
    endfunction

    // ---------------- driver ----------------
    task automatic issue8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int waited;
        logic [9:0] m;
        waited = 0;
        @(negedge clk);
        bus8.in_valid = 1'b1;
        bus8.select   = op;
        bus8.data1    = a;
        bus8.data2    = b;
        #1;
        while (!bus8.in_ready && waited < 60) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!bus8.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1 (op %0d)", op);
            bus8.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        m = model8(op, a, b);
        exp_q.push_back(m[7:0]);
        flag_q.push_back(m[9:8]);
        due_q.push_back(cycle + lat8(op, b) - 1);
        bus8.in_valid = 1'b0;
    endtask

    // ---------------- compare process ----------------
    logic       prev_valid = 1'b0;
    logic       prev_taken = 1'b0;
    logic [7:0] prev_res   = 8'h00;
    logic [7:0] e_res;
    logic [1:0] e_flag;
    int         e_due;

    always @(negedge clk) begin
        #2;
        if (!reset) begin
            exp_q.delete();
            flag_q.delete();
            due_q.delete();
            prev_valid = 1'b0;
            prev_taken = 1'b0;
        end else begin
            if (prev_valid && !prev_taken) begin
                check("hold_valid", bus8.out_valid, 1'b1);
                check("hold_result", bus8.result, prev_res);
            end else if (bus8.out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %0h expected none", bus8.result);
                end else begin
                    e_res  = exp_q.pop_front();
                    e_flag = flag_q.pop_front();
                    e_due  = due_q.pop_front();
                    check("result", bus8.result, e_res);
                    check("zero", bus8.zero, (e_res == 8'h00));
                    check("latency_cycle", cycle, e_due);
`ifdef ALU_FLAGS_EN
                    check("carry", bus8.carry, e_flag[0]);
                    check("overflow", bus8.overflow, e_flag[1]);
`endif
                end
            end
            prev_valid = bus8.out_valid;
            prev_taken = bus8.out_valid && bus8.out_ready;
            prev_res   = bus8.result;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    logic [9:0] m;
    int         k;
    int         waited;

    initial begin
        reset          = 1'b0;
        bus8.in_valid  = 1'b0;
        bus8.select    = ALU_FWD;
        bus8.data1     = 8'h00;
        bus8.data2     = 8'h00;
        bus8.out_ready = 1'b1;
        bus16.in_valid  = 1'b0;
        bus16.select    = ALU_FWD;
        bus16.data1     = 16'h0000;
        bus16.data2     = 16'h0000;
        bus16.out_ready = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        #3;
        check("rst_out_valid", bus8.out_valid, 1'b0);
        check("rst_result", bus8.result, 8'h00);
        check("rst_zero", bus8.zero, 1'b1);
        check("rst_in_ready", bus8.in_ready, 1'b0);
        check("rst_state", st8, ST_IDLE);
        reset = 1'b1;

        // Pin the model with hand-computed values
        m = model8(ALU_ADD, 8'h8F, 8'h09); check("pin_add", m[7:0], 8'h98);
        m = model8(ALU_SUB, 8'h05, 8'h05); check("pin_sub", m[7:0], 8'h00);
        m = model8(ALU_AND, 8'h0F, 8'h59); check("pin_and", m[7:0], 8'h09);
        m = model8(ALU_OR,  8'h0F, 8'h79); check("pin_or", m[7:0], 8'h7F);
        m = model8(ALU_SRA, 8'h90, 8'h03); check("pin_sra", m[7:0], 8'hF2);
        m = model8(ALU_SRL, 8'h90, 8'h09); check("pin_srl9", m[7:0], 8'h00);
        m = model8(ALU_SLL, 8'h81, 8'h00); check("pin_sll0", m[7:0], 8'h81);
        m = model8(ALU_ADD, 8'h7F, 8'h01); check("pin_add_flags", m, {1'b1, 1'b0, 8'h80});
        m = model8(ALU_SUB, 8'h00, 8'h01); check("pin_sub_flags", m, {1'b0, 1'b0, 8'hFF});
        m = model8(ALU_SRL, 8'h03, 8'h01); check("pin_srl_carry", m[8], 1'b1);
        check("pin_lat_sra3", lat8(ALU_SRA, 8'h03), 4);

        // Reset in the middle of SLL by 5
        issue8(ALU_SLL, 8'h01, 8'h05);
        @(negedge clk);
        #3;
        check("mid_shift_state", st8, ST_SHIFT);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        check("rst2_out_valid", bus8.out_valid, 1'b0);
        check("rst2_result", bus8.result, 8'h00);
        check("rst2_zero", bus8.zero, 1'b1);
        check("rst2_in_ready", bus8.in_ready, 1'b0);
        check("rst2_state", st8, ST_IDLE);
        reset = 1'b1;
        @(negedge clk);
        #3;
        check("post_rst_in_ready", bus8.in_ready, 1'b1);

        // Back-to-back single-cycle ops
        issue8(ALU_ADD, 8'h8F, 8'h09);
        issue8(ALU_SUB, 8'h05, 8'h05);
        issue8(ALU_AND, 8'h0F, 8'h59);
        issue8(ALU_OR,  8'h0F, 8'h79);
        issue8(ALU_FWD, 8'hA5, 8'h3C);
        issue8(ALU_ADD, 8'hFF, 8'h01);
        issue8(ALU_SUB, 8'h80, 8'h01);

        // SRA by 3: in_ready low while shifting
        issue8(ALU_SRA, 8'h90, 8'h03);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #3;
            check("shift_in_ready", bus8.in_ready, 1'b0);
            check("shift_state", st8, ST_SHIFT);
        end
        issue8(ALU_SRL, 8'h90, 8'h09);
        issue8(ALU_SLL, 8'h81, 8'h00);
        issue8(ALU_SRA, 8'h90, 8'h0F);
        issue8(ALU_SLL, 8'hFF, 8'h04);
        issue8(ALU_SRL, 8'h03, 8'h01);
        issue8(ALU_SLL, 8'h81, 8'h08);
        issue8(ALU_ADD, 8'h7F, 8'h01);
        issue8(ALU_SUB, 8'h00, 8'h01);

        // Drain before backpressure
        waited = 0;
        while (exp_q.size() != 0 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("drain1", exp_q.size(), 0);

        // Backpressure: ADD 1+2 held while OUT_READY=0
        @(negedge clk);
        bus8.out_ready = 1'b0;
        issue8(ALU_ADD, 8'h01, 8'h02);
        fork
            issue8(ALU_OR, 8'h10, 8'h01);
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    #3;
                    check("bp_result", bus8.result, 8'h03);
                    check("bp_out_valid", bus8.out_valid, 1'b1);
                    check("bp_in_ready", bus8.in_ready, 1'b0);
                end
                @(negedge clk);
                bus8.out_ready = 1'b1;
            end
        join

        waited = 0;
        while (exp_q.size() != 0 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("drain2", exp_q.size(), 0);

        // WIDTH=16, SHIFT_STEP=4: SLL 1 by 10, then SRA 8000 by 16
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            bus16.in_valid = 1'b1;
            bus16.select   = (t == 0) ? ALU_SLL : ALU_SRA;
            bus16.data1    = (t == 0) ? 16'h0001 : 16'h8000;
            bus16.data2    = (t == 0) ? 16'd10 : 16'd16;
            #1;
            check("w16_in_ready", bus16.in_ready, 1'b1);
            @(posedge clk);
            #1;
            bus16.in_valid = 1'b0;
            k = 0;
            while (k < 20) begin
                @(negedge clk);
                #3;
                k++;
                if (bus16.out_valid) break;
            end
            check("w16_latency", k, (t == 0) ? 4 : 5);
            check("w16_result", bus16.result, (t == 0) ? 16'h0400 : 16'hFFFF);
            check("w16_zero", bus16.zero, 1'b0);
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
